// File: rtl/ex_mem_if.sv
// EX/MEM boundary bundle: EX-side instruction and control inputs, MEM-side
// registered outputs, stall and the fetch redirect.
interface ex_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_W       = 9,
   parameter int REG_W      = 5
);
   logic                  stall;

   logic                  ex_valid;
   logic [DATA_WIDTH-1:0] ex_alu_result;
   logic [PC_W-1:0]       ex_pc;
   logic [PC_W-1:0]       ex_imm;
   logic [DATA_WIDTH-1:0] ex_rs2_data;
   logic [REG_W-1:0]      ex_rd;
   logic                  ex_reg_write;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic                  ex_mem_to_reg;
   logic                  ex_branch;
   logic                  ex_jump;

   logic                  mem_valid;
   logic [DATA_WIDTH-1:0] mem_alu_result;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [REG_W-1:0]      mem_rd;
   logic                  mem_reg_write;
   logic                  mem_mem_read;
   logic                  mem_mem_write;
   logic                  mem_mem_to_reg;

   logic                  redirect;
   logic [PC_W-1:0]       redirect_pc;
   logic                  misalign_err;

   // Driven by the execute stage / core control
   modport master (
      output stall,
      output ex_valid, ex_alu_result, ex_pc, ex_imm, ex_rs2_data, ex_rd,
      output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
      output ex_branch, ex_jump,
      input  mem_valid, mem_alu_result, mem_wdata, mem_rd,
      input  mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
      input  redirect, redirect_pc, misalign_err
   );

   // The pipeline register itself
   modport slave (
      input  stall,
      input  ex_valid, ex_alu_result, ex_pc, ex_imm, ex_rs2_data, ex_rd,
      input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
      input  ex_branch, ex_jump,
      output mem_valid, mem_alu_result, mem_wdata, mem_rd,
      output mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
      output redirect, redirect_pc, misalign_err
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution, one-cycle redirect and
// wrong-path squashing. Optional target alignment check: EX_MEM_MISALIGN_CHECK_EN.
module ex_mem_stage #(
   parameter int DATA_WIDTH   = 32,
   parameter int PC_W         = 9,
   parameter int REG_W        = 5,
   parameter int SQUASH_DEPTH = 2
) (
   input  logic     clk,
   input  logic     reset,
   ex_mem_if.slave  bus
);

   typedef enum logic {
      RUN,
      SQUASH
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      sq_cnt;
   logic [1:0]      sq_cnt_nxt;

   logic            take;
   logic            taken;
   logic            misaligned;
   logic            do_redirect;
   logic            capture_valid;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] link_pc;

   // Resolve the EX slot and decide where the squash FSM goes next
   always_comb begin
      state_nxt     = state;
      sq_cnt_nxt    = sq_cnt;
      target        = bus.ex_pc + bus.ex_imm;
      link_pc       = bus.ex_pc + PC_W'(4);
      take          = bus.ex_valid && (state == RUN);
      taken         = take && (bus.ex_jump || (bus.ex_branch && bus.ex_alu_result[0]));
      misaligned    = 1'b0;
`ifdef EX_MEM_MISALIGN_CHECK_EN
      misaligned    = taken && (target[1:0] != 2'b00);
`endif
      do_redirect   = taken && !misaligned;
      capture_valid = take && !misaligned;

      if (!bus.stall) begin
         case (state)
            RUN: begin
               if (do_redirect) begin
                  state_nxt  = SQUASH;
                  sq_cnt_nxt = 2'(SQUASH_DEPTH);
               end
            end
            SQUASH: begin
               sq_cnt_nxt = sq_cnt - 2'd1;
               if (sq_cnt <= 2'd1) begin
                  state_nxt  = RUN;
                  sq_cnt_nxt = 2'd0;
               end
            end
            default: begin
               state_nxt  = RUN;
               sq_cnt_nxt = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         sq_cnt <= 2'd0;
      end else begin
         state  <= state_nxt;
         sq_cnt <= sq_cnt_nxt;
      end
   end

   // MEM slot capture; a stall freezes everything here
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_valid      <= 1'b0;
         bus.mem_alu_result <= '0;
         bus.mem_wdata      <= '0;
         bus.mem_rd         <= '0;
         bus.mem_reg_write  <= 1'b0;
         bus.mem_mem_read   <= 1'b0;
         bus.mem_mem_write  <= 1'b0;
         bus.mem_mem_to_reg <= 1'b0;
         bus.redirect_pc    <= '0;
      end else if (!bus.stall) begin
         bus.mem_valid      <= capture_valid;
         bus.mem_alu_result <= bus.ex_jump ? DATA_WIDTH'(link_pc) : bus.ex_alu_result;
         bus.mem_wdata      <= bus.ex_rs2_data;
         bus.mem_rd         <= bus.ex_rd;
         bus.mem_reg_write  <= bus.ex_reg_write  && capture_valid;
         bus.mem_mem_read   <= bus.ex_mem_read   && capture_valid;
         bus.mem_mem_write  <= bus.ex_mem_write  && capture_valid;
         bus.mem_mem_to_reg <= bus.ex_mem_to_reg && capture_valid;
         bus.redirect_pc    <= target;
      end
   end

   // The redirect pulse ignores stall on its falling edge so it never repeats
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.redirect <= 1'b0;
      end else begin
         bus.redirect <= do_redirect && !bus.stall;
      end
   end

`ifdef EX_MEM_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.misalign_err <= 1'b0;
      end else if (misaligned && !bus.stall) begin
         bus.misalign_err <= 1'b1;
      end
   end
`else
   assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: capture, branch squash, JAL
// link/wrap, stall behaviour, reset during squash and the alignment option.
module tb_ex_mem_stage;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   ex_mem_if #(.DATA_WIDTH(32), .PC_W(9), .REG_W(5)) bus ();

   ex_mem_stage #(
      .DATA_WIDTH(32), .PC_W(9), .REG_W(5), .SQUASH_DEPTH(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(
      input logic        valid,
      input logic [31:0] alu,
      input logic [8:0]  pc,
      input logic [8:0]  imm,
      input logic [4:0]  rd,
      input logic        rw,
      input logic        mr,
      input logic        mw,
      input logic        m2r,
      input logic        br,
      input logic        jp
   );
      bus.ex_valid      = valid;
      bus.ex_alu_result = alu;
      bus.ex_pc         = pc;
      bus.ex_imm        = imm;
      bus.ex_rs2_data   = alu ^ 32'hA5A5_0000;
      bus.ex_rd         = rd;
      bus.ex_reg_write  = rw;
      bus.ex_mem_read   = mr;
      bus.ex_mem_write  = mw;
      bus.ex_mem_to_reg = m2r;
      bus.ex_branch     = br;
      bus.ex_jump       = jp;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      bus.stall = 1'b0;
      applyStimulus(1'b0, 32'h0, 9'h0, 9'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("rst_alu", bus.mem_alu_result, 32'd0);
      checkOutput("rst_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("rst_redirect_pc", 32'(bus.redirect_pc), 32'd0);
      checkOutput("rst_misalign", 32'(bus.misalign_err), 32'd0);

      // Plain ALU op
      reset = 1'b0;
      applyStimulus(1'b1, 32'h5, 9'h010, 9'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("alu_valid", 32'(bus.mem_valid), 32'd1);
      checkOutput("alu_result", bus.mem_alu_result, 32'd5);
      checkOutput("alu_rd", 32'(bus.mem_rd), 32'd7);
      checkOutput("alu_rw", 32'(bus.mem_reg_write), 32'd1);
      checkOutput("alu_wdata", bus.mem_wdata, 32'hA5A5_0005);
      checkOutput("alu_redirect", 32'(bus.redirect), 32'd0);

      // Taken BEQ followed by two squashed instructions
      applyStimulus(1'b1, 32'h1, 9'h040, 9'h010, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("beq_redirect", 32'(bus.redirect), 32'd1);
      checkOutput("beq_target", 32'(bus.redirect_pc), 32'h050);
      applyStimulus(1'b1, 32'h11, 9'h044, 9'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("sq1_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("sq1_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("sq1_rw", 32'(bus.mem_reg_write), 32'd0);
      tick();
      checkOutput("sq2_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("sq2_rw", 32'(bus.mem_reg_write), 32'd0);
      tick();
      checkOutput("post_sq_valid", 32'(bus.mem_valid), 32'd1);
      checkOutput("post_sq_rw", 32'(bus.mem_reg_write), 32'd1);
      checkOutput("post_sq_alu", bus.mem_alu_result, 32'h11);

      // JAL: link value and target wrap
      applyStimulus(1'b1, 32'hDEAD, 9'h020, 9'h1F0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("jal_link", bus.mem_alu_result, 32'h024);
      checkOutput("jal_target", 32'(bus.redirect_pc), 32'h010);
      checkOutput("jal_redirect", 32'(bus.redirect), 32'd1);
      checkOutput("jal_rw", 32'(bus.mem_reg_write), 32'd1);
      applyStimulus(1'b0, 32'h0, 9'h0, 9'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("jal_pulse_end", 32'(bus.redirect), 32'd0);
      tick();

      // Branch from the last address wraps to 0x004
      applyStimulus(1'b1, 32'h1, 9'h1FC, 9'h008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("wrap_target", 32'(bus.redirect_pc), 32'h004);
      checkOutput("wrap_redirect", 32'(bus.redirect), 32'd1);
      applyStimulus(1'b0, 32'h0, 9'h0, 9'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();

      // Load capture, then three stalled cycles with different EX contents
      applyStimulus(1'b1, 32'h100, 9'h060, 9'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("ld_mem_read", 32'(bus.mem_mem_read), 32'd1);
      bus.stall = 1'b1;
      applyStimulus(1'b1, 32'h55, 9'h064, 9'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_alu", bus.mem_alu_result, 32'h100);
         checkOutput("stall_rd", 32'(bus.mem_rd), 32'd9);
         checkOutput("stall_mem_read", 32'(bus.mem_mem_read), 32'd1);
         checkOutput("stall_mem_write", 32'(bus.mem_mem_write), 32'd0);
      end

      // Taken branch held in EX by the stall
      applyStimulus(1'b1, 32'h1, 9'h080, 9'h020, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("stall_br_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("stall_br_alu", bus.mem_alu_result, 32'h100);
      bus.stall = 1'b0;
      tick();
      checkOutput("unstall_redirect", 32'(bus.redirect), 32'd1);
      checkOutput("unstall_target", 32'(bus.redirect_pc), 32'h0A0);
      bus.stall = 1'b1;
      applyStimulus(1'b1, 32'h33, 9'h084, 9'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("stall_pulse_end", 32'(bus.redirect), 32'd0);
      checkOutput("stall_pulse_target", 32'(bus.redirect_pc), 32'h0A0);

      // One bubble leaves the counter at 1, then reset mid-squash
      bus.stall = 1'b0;
      tick();
      checkOutput("sq_bubble", 32'(bus.mem_valid), 32'd0);
      reset = 1'b1;
      tick();
      checkOutput("rst_sq_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("rst_sq_alu", bus.mem_alu_result, 32'd0);
      checkOutput("rst_sq_target", 32'(bus.redirect_pc), 32'd0);
      checkOutput("rst_sq_redirect", 32'(bus.redirect), 32'd0);
      reset = 1'b0;
      applyStimulus(1'b1, 32'h77, 9'h100, 9'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("after_rst_valid", 32'(bus.mem_valid), 32'd1);
      checkOutput("after_rst_alu", bus.mem_alu_result, 32'h77);

      // Taken branch to a misaligned target 0x052
      applyStimulus(1'b1, 32'h1, 9'h040, 9'h012, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
`ifdef EX_MEM_MISALIGN_CHECK_EN
      checkOutput("mis_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("mis_valid", 32'(bus.mem_valid), 32'd0);
      checkOutput("mis_err", 32'(bus.misalign_err), 32'd1);
      applyStimulus(1'b1, 32'h9, 9'h044, 9'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("mis_no_squash", 32'(bus.mem_valid), 32'd1);
      checkOutput("mis_err_sticky", 32'(bus.misalign_err), 32'd1);
`else
      checkOutput("mis_redirect", 32'(bus.redirect), 32'd1);
      checkOutput("mis_target", 32'(bus.redirect_pc), 32'h052);
      checkOutput("mis_err", 32'(bus.misalign_err), 32'd0);
      applyStimulus(1'b0, 32'h0, 9'h0, 9'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
`endif
      reset = 1'b1;
      tick();
      checkOutput("final_rst_err", 32'(bus.misalign_err), 32'd0);
      checkOutput("final_rst_valid", 32'(bus.mem_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the execute stage (ALU) and the memory stage of the RV32I core. Captures the ALU result and the EX control bundle, resolves conditional branches and jumps from the ALU compare result, and issues a one-cycle PC redirect. Squashes the wrong-path instructions that follow a taken branch so they reach MEM as bubbles. Honours a global stall by holding all state.

## Interface
- DATA_WIDTH, 32, datapath width
- PC_W, 9, program-counter width (byte address)
- REG_W, 5, register-index width
- SQUASH_DEPTH, 2, wrong-path instructions discarded after a taken redirect (1..3)

- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold: no capture, all registered state frozen except redirect
- ex_valid  in  1  EX slot holds a real instruction
- ex_alu_result  in  DATA_WIDTH  ALU output; bit 0 is the branch condition for branch ops
- ex_pc  in  PC_W  PC of the EX instruction
- ex_imm  in  PC_W  branch/jump offset (already sign-truncated to PC_W)
- ex_rs2_data  in  DATA_WIDTH  store data
- ex_rd  in  REG_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_jump  in  1 each  control bundle
- mem_valid  out  1  MEM slot holds a real instruction
- mem_alu_result  out  DATA_WIDTH  address/result forwarded to MEM
- mem_wdata  out  DATA_WIDTH  store data
- mem_rd  out  REG_W
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each  gated by mem_valid
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  PC_W  branch/jump target
- misalign_err  out  1  sticky target-misalignment flag (see Configuration)

## Operation
- Reset: all outputs 0, squash counter 0, state RUN.
- Capture (stall=0 each edge): take = ex_valid and not squashing; taken = take and (ex_jump or (ex_branch and ex_alu_result[0])).
- mem_valid <= take; data fields captured unconditionally; mem_reg_write/mem_mem_read/mem_mem_write/mem_mem_to_reg <= ex_* AND take.
- mem_alu_result <= ex_jump ? zero-extended (ex_pc + 4) : ex_alu_result (link value for JAL/JALR).
- redirect_pc <= ex_pc + ex_imm, modulo 2^PC_W (wraps, no carry out).
- States: RUN, SQUASH.
  - RUN -> SQUASH on taken capture; counter <= SQUASH_DEPTH.
  - SQUASH: each non-stalled edge captures a bubble (mem_valid=0, enables 0, no redirect even if the slot is a branch) and decrements the counter; on the edge where the counter reaches 0 -> RUN. Counter decrements regardless of ex_valid.
- Stall: all mem_* fields, state and counter hold.

## Timing
- Latency 1 cycle EX -> MEM.
- redirect asserted exactly in the cycle after the taken capture edge; deasserts the next edge unconditionally, including when stall=1 in that cycle (never repeated).
- Stall and taken branch present together: nothing captured; branch stays in EX and resolves on the first non-stalled edge.
- reset mid-SQUASH: returns to RUN, counter 0, redirect 0 on the same edge.
- Branch on last address (ex_pc=0x1FC, ex_imm=0x008): redirect_pc=0x004.

## Configuration
- EX_MEM_MISALIGN_CHECK_EN defined: a taken target with redirect_pc[1:0]≠0 suppresses the redirect, enters no SQUASH, captures the instruction as a bubble, and sets misalign_err (sticky until reset).
- Undefined: no check, misaligned targets redirect normally, misalign_err tied 0.

## Test plan
- Plain ALU op: ex_valid=1, ex_alu_result=0x0000_0005, rd=7, reg_write=1 -> next cycle mem_valid=1, mem_alu_result=5, mem_rd=7, mem_reg_write=1, redirect=0.
- Taken BEQ: ex_branch=1, ex_alu_result=1, ex_pc=0x040, ex_imm=0x010 -> redirect=1 for one cycle, redirect_pc=0x050; next two EX instructions (valid, reg_write=1) emerge with mem_valid=0, mem_reg_write=0; third passes.
- JAL: ex_jump=1, ex_pc=0x020, ex_imm=0x1F0 -> mem_alu_result=0x024, redirect_pc=0x010 (wrap), redirect pulse.
- Stall: stall=1 for 3 cycles after a load capture -> mem_* unchanged; taken branch held in EX during stall -> redirect only after stall drops; stall in redirect cycle -> redirect still lasts exactly 1 cycle.
- Reset in SQUASH with counter=1 -> all outputs 0; next valid EX instruction passes with mem_valid=1.
- With EX_MEM_MISALIGN_CHECK_EN: taken branch to 0x052 -> redirect=0, mem_valid=0, misalign_err=1 and stays 1 until reset; without macro -> redirect_pc=0x052, misalign_err=0.
